// File: rtl/dst40_pkg.sv
// Shared DST40 constants and the key-sweeper state encoding.
package dst40_pkg;

  localparam int KEY_W           = 40;
  localparam int RESP_W          = 24;
  localparam int DEFAULT_LATENCY = 64;  // depth of the 64-stage hashing kernel

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SWEEP,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/dst40_prio_enc.sv
// Lowest-set-bit encoder for the kernel comparator lines.
module dst40_prio_enc #(
  parameter int L2NK = 1,
  parameter int NK   = 2 ** L2NK
) (
  input  logic [NK-1:0]   req,
  output logic [L2NK-1:0] idx,
  output logic            valid
);

  // NOTE: idx gets a default before the loop so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    idx = '0;
    for (int i = NK - 1; i >= 0; i--) begin
      if (req[i]) idx = L2NK'(i);
    end
  end

  assign valid = |req;

endmodule

// File: rtl/dst40_key_sweeper.sv
// Issues a key range to the DST40 kernel array and recovers the full key
// behind any comparator hit once the kernel pipeline has filled.
module dst40_key_sweeper
  import dst40_pkg::*;
#(
  parameter int L2NK        = 1,
  parameter int NK          = 2 ** L2NK,
  parameter int LATENCY     = DEFAULT_LATENCY,
  parameter int STOP_ON_HIT = 0
) (
  input  logic                   clock_i,
  input  logic                   reset_n_i,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic                   pause_i,
  input  logic [KEY_W-L2NK-1:0]  start_key_i,
  input  logic [KEY_W-L2NK-1:0]  end_key_i,
  input  logic [NK-1:0]          match_i,
  output logic                   run_o,
  output logic [KEY_W-L2NK-1:0]  key_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   found_o,
  output logic [KEY_W-1:0]       found_key_o,
  output logic [7:0]             hit_count_o
);

  localparam int LW = KEY_W - L2NK;
  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [LW-1:0] LAT_KEY = LW'(LATENCY);
  localparam logic [CW-1:0] LAT_CNT = CW'(LATENCY);

  state_t          state;
  logic [LW-1:0]   remaining;
  logic [CW-1:0]   drain_cnt;
  logic [CW-1:0]   fill;
  logic [L2NK-1:0] hit_idx;
  logic            hit_any;
  logic            start_ok;
  logic            valid_hit;

  dst40_prio_enc #(.L2NK(L2NK), .NK(NK)) u_prio_enc (
    .req   (match_i),
    .idx   (hit_idx),
    .valid (hit_any)
  );

  assign busy_o   = (state == ST_SWEEP) || (state == ST_DRAIN);
  assign done_o   = (state == ST_DONE);
  assign run_o    = busy_o & ~pause_i;
  assign start_ok = start_i && !stop_i && ((state == ST_IDLE) || (state == ST_DONE));
  // Results still in flight from before this start are masked until fill saturates.
  assign valid_hit = run_o && !stop_i && (fill == LAT_CNT) && hit_any;

  // NOTE: all state updates use <= so every branch sees the pre-edge values of
  // key_o, remaining and the counters, independent of statement order.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state       <= ST_IDLE;
      key_o       <= '0;
      remaining   <= '0;
      drain_cnt   <= '0;
      fill        <= '0;
      found_o     <= 1'b0;
      found_key_o <= '0;
      hit_count_o <= '0;
    end else begin
      found_o <= 1'b0;
      if (stop_i) begin
        state <= ST_IDLE;
      end else if (start_ok) begin
        state       <= ST_SWEEP;
        key_o       <= start_key_i;
        remaining   <= end_key_i - start_key_i;
        fill        <= '0;
        hit_count_o <= '0;
      end else if (run_o) begin
        key_o <= key_o + 1'b1;
        if (fill != LAT_CNT) fill <= fill + 1'b1;

        case (state)
          ST_SWEEP: begin
            if (remaining == '0) begin
              state     <= ST_DRAIN;
              drain_cnt <= LAT_CNT;
            end else begin
              remaining <= remaining - 1'b1;
            end
          end
          ST_DRAIN: begin
            drain_cnt <= drain_cnt - 1'b1;
            if (drain_cnt == CW'(1)) state <= ST_DONE;
          end
          default: ;
        endcase

        // The matching key left key_o LATENCY enabled edges ago.
        if (valid_hit) begin
          found_o     <= 1'b1;
          found_key_o <= {hit_idx, key_o - LAT_KEY};
          if (hit_count_o != 8'hFF) hit_count_o <= hit_count_o + 1'b1;
          if (STOP_ON_HIT != 0) state <= ST_DONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_dst40_key_sweeper.sv
// Scoreboard bench for dst40_key_sweeper with a behavioural delay-line kernel model.
module tb_dst40_key_sweeper;

  localparam int L2NK = 1;
  localparam int NK   = 2;
  localparam int LW   = 39;
  localparam int LAT  = 64;

  logic          clock_i = 1'b0;
  logic          reset_n_i = 1'b0;
  logic          start_i = 1'b0;
  logic          stop_i = 1'b0;
  logic          pause_i = 1'b0;
  logic [LW-1:0] start_key_i = '0;
  logic [LW-1:0] end_key_i = '0;

  logic [NK-1:0] match0, match1;
  logic          run0, busy0, done0, found0;
  logic          run1, busy1, done1, found1;
  logic [LW-1:0] key0, key1;
  logic [39:0]   fk0, fk1;
  logic [7:0]    hc0, hc1;

  // Kernel model state: planted low key, per-kernel enables, forced match.
  logic [LW-1:0] plant_low = '0;
  logic [NK-1:0] plant_en = '0;
  logic          force_match = 1'b0;
  logic [LW-1:0] pipe0 [LAT];
  logic [LW-1:0] pipe1 [LAT];

  int checks = 0;
  int errors = 0;
  int pulses0 = 0;
  int pulses1 = 0;
  logic [39:0] exp_q [$];
  logic        d1_done_at_hit, d1_busy_at_hit;
  logic [LW-1:0] d1_key_at_hit;
  logic [39:0] d1_fk;

  always #5 clock_i = ~clock_i;

  dst40_key_sweeper #(.L2NK(L2NK), .NK(NK), .LATENCY(LAT), .STOP_ON_HIT(0)) dut0 (
    .clock_i(clock_i), .reset_n_i(reset_n_i), .start_i(start_i), .stop_i(stop_i),
    .pause_i(pause_i), .start_key_i(start_key_i), .end_key_i(end_key_i),
    .match_i(match0), .run_o(run0), .key_o(key0), .busy_o(busy0), .done_o(done0),
    .found_o(found0), .found_key_o(fk0), .hit_count_o(hc0)
  );

  dst40_key_sweeper #(.L2NK(L2NK), .NK(NK), .LATENCY(LAT), .STOP_ON_HIT(1)) dut1 (
    .clock_i(clock_i), .reset_n_i(reset_n_i), .start_i(start_i), .stop_i(stop_i),
    .pause_i(pause_i), .start_key_i(start_key_i), .end_key_i(end_key_i),
    .match_i(match1), .run_o(run1), .key_o(key1), .busy_o(busy1), .done_o(done1),
    .found_o(found1), .found_key_o(fk1), .hit_count_o(hc1)
  );

  always @(posedge clock_i) begin
    if (run0) begin
      for (int i = LAT - 1; i > 0; i--) pipe0[i] <= pipe0[i-1];
      pipe0[0] <= key0;
    end
    if (run1) begin
      for (int i = LAT - 1; i > 0; i--) pipe1[i] <= pipe1[i-1];
      pipe1[0] <= key1;
    end
  end

  always_comb begin
    match0 = '0;
    match1 = '0;
    if (force_match) begin
      match0 = '1;
      match1 = '1;
    end else begin
      for (int j = 0; j < NK; j++) begin
        match0[j] = plant_en[j] && (pipe0[LAT-1] == plant_low);
        match1[j] = plant_en[j] && (pipe1[LAT-1] == plant_low);
      end
    end
  end

  // One clock; sample #1 after the edge and retire any found_o against the scoreboard.
  task automatic tick();
    logic [39:0] exp;
    @(posedge clock_i);
    #1;
    if (found0) begin
      pulses0++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_unexpected_hit: found_key_o=%h, none expected", fk0);
      end else begin
        exp = exp_q.pop_front();
        if (fk0 !== exp) begin
          errors++;
          $display("FAIL scoreboard_found_key: got %h, expected %h", fk0, exp);
        end
      end
    end
    if (found1) begin
      pulses1++;
      d1_done_at_hit = done1;
      d1_busy_at_hit = busy1;
      d1_key_at_hit  = key1;
      d1_fk          = fk1;
    end
  endtask

  task automatic plant(input logic [LW-1:0] low, input logic [NK-1:0] en, input logic [39:0] exp);
    plant_low = low;
    plant_en  = en;
    exp_q.push_back(exp);
  endtask

  task automatic pulse_start(input logic [LW-1:0] s, input logic [LW-1:0] e);
    start_key_i = s;
    end_key_i   = e;
    start_i     = 1'b1;
    tick();
    start_i     = 1'b0;
  endtask

  // Counts busy cycles of both DUTs until dut0 reaches DONE; poke>0 re-asserts start there.
  task automatic wait_done(input int budget, input int poke, output int b0, output int b1);
    bit timed_out;
    b0 = 0;
    b1 = 0;
    timed_out = 1'b1;
    for (int c = 1; c <= budget; c++) begin
      if (busy0) b0++;
      if (busy1) b1++;
      if (done0) begin
        timed_out = 1'b0;
        break;
      end
      start_i = (c == poke);
      if (c == poke) begin
        start_key_i = 39'h7000;
        end_key_i   = 39'h7000;
      end
      tick();
    end
    start_i = 1'b0;
    checks++;
    if (timed_out) begin
      errors++;
      $display("FAIL wait_done_timeout: done_o not seen within %0d cycles", budget);
    end
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0;
    repeat (2) tick();
    checks++;
    if ({run0, busy0, done0, found0, hc0, key0, fk0} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: run/busy/done/found=%b%b%b%b hit_count=%h key=%h found_key=%h, all zero expected",
               run0, busy0, done0, found0, hc0, key0, fk0);
    end
    reset_n_i = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int b0, b1;
    pulses0 = 0;
    plant(39'h12, 2'b10, 40'h80_0000_0012);
    pulse_start(39'h10, 39'h13);
    checks++;
    if ({run0, key0} !== {1'b1, 39'h10}) begin
      errors++;
      $display("FAIL first_cycle: run_o=%b key_o=%h, expected 1 and 10", run0, key0);
    end
    wait_done(400, 10, b0, b1);
    checks++;
    if (b0 !== 68) begin
      errors++;
      $display("FAIL basic_busy_cycles: got %0d, expected 68", b0);
    end
    checks++;
    if (pulses0 !== 1 || hc0 !== 8'd1) begin
      errors++;
      $display("FAIL basic_hits: pulses=%0d hit_count=%0d, expected 1 and 1", pulses0, hc0);
    end
    repeat (3) tick();
    checks++;
    if (done0 !== 1'b1 || fk0 !== 40'h80_0000_0012) begin
      errors++;
      $display("FAIL done_holds: done_o=%b found_key=%h, expected 1 and 8000000012", done0, fk0);
    end
  endtask

  task automatic test_wrap();
    int b0, b1;
    pulses0 = 0;
    plant(39'h7F_FFFF_FFFF, 2'b01, 40'h7F_FFFF_FFFF);
    pulse_start(39'h7F_FFFF_FFFE, 39'h1);
    checks++;
    if (hc0 !== 8'd0 || fk0 !== 40'h80_0000_0012) begin
      errors++;
      $display("FAIL restart_from_done: hit_count=%0d found_key=%h, expected 0 and 8000000012", hc0, fk0);
    end
    wait_done(400, 0, b0, b1);
    checks++;
    if (b0 !== 68 || pulses0 !== 1) begin
      errors++;
      $display("FAIL wrap_sweep: busy=%0d pulses=%0d, expected 68 and 1", b0, pulses0);
    end
  endtask

  task automatic test_single_key();
    int b0, b1;
    pulses0 = 0;
    plant(39'h55, 2'b01, 40'h55);
    pulse_start(39'h55, 39'h55);
    wait_done(400, 0, b0, b1);
    checks++;
    if (b0 !== 65 || pulses0 !== 1) begin
      errors++;
      $display("FAIL single_key: busy=%0d pulses=%0d, expected 65 and 1", b0, pulses0);
    end
  endtask

  task automatic test_dup_and_stop_on_hit();
    int b0, b1;
    pulses0 = 0;
    pulses1 = 0;
    plant(39'h33, 2'b11, 40'h33);
    pulse_start(39'h30, 39'h93);
    wait_done(600, 0, b0, b1);
    checks++;
    if (b0 !== 164 || pulses0 !== 1 || hc0 !== 8'd1) begin
      errors++;
      $display("FAIL dup_hit: busy=%0d pulses=%0d hit_count=%0d, expected 164 1 1", b0, pulses0, hc0);
    end
    checks++;
    if (pulses1 !== 1 || d1_done_at_hit !== 1'b1 || d1_busy_at_hit !== 1'b0 || d1_fk !== 40'h33) begin
      errors++;
      $display("FAIL stop_on_hit_done: pulses=%0d done=%b busy=%b found_key=%h, expected 1 1 0 33",
               pulses1, d1_done_at_hit, d1_busy_at_hit, d1_fk);
    end
    checks++;
    if (d1_key_at_hit !== 39'h74 || b1 !== 68) begin
      errors++;
      $display("FAIL stop_on_hit_early: key_o=%h busy=%0d, expected 74 and 68", d1_key_at_hit, b1);
    end
  endtask

  task automatic test_pause();
    int cnt;
    bit timed_out;
    logic [LW-1:0] hold_a, hold_b;
    pulses0 = 0;
    cnt = 0;
    timed_out = 1'b1;
    hold_a = '0;
    hold_b = '0;
    plant(39'h205, 2'b01, 40'h205);
    pulse_start(39'h200, 39'h213);
    for (int c = 1; c <= 400; c++) begin
      if (busy0) cnt++;
      if (done0) begin
        timed_out = 1'b0;
        break;
      end
      pause_i = (c >= 5 && c <= 14) || (c >= 50 && c <= 59);
      if (c == 5) hold_a = key0;
      if (c == 50) hold_b = key0;
      if (c == 10) begin
        #1;
        checks++;
        if (run0 !== 1'b0) begin
          errors++;
          $display("FAIL pause_run: run_o=%b, expected 0", run0);
        end
      end
      if (c == 15) begin
        checks++;
        if (key0 !== hold_a || hold_a !== 39'h204) begin
          errors++;
          $display("FAIL pause_sweep_freeze: key_o=%h held=%h, expected 204", key0, hold_a);
        end
      end
      if (c == 60) begin
        checks++;
        if (key0 !== hold_b) begin
          errors++;
          $display("FAIL pause_drain_freeze: key_o=%h, expected %h", key0, hold_b);
        end
      end
      tick();
    end
    pause_i = 1'b0;
    checks++;
    if (timed_out || cnt !== 104 || pulses0 !== 1) begin
      errors++;
      $display("FAIL pause_busy: busy=%0d pulses=%0d timeout=%b, expected 104 1 0", cnt, pulses0, timed_out);
    end
  endtask

  task automatic test_stale_pipeline();
    int b0, b1;
    pulses0 = 0;
    plant_en = 2'b00;
    pulse_start(39'h100, 39'h1FF);
    force_match = 1'b1;
    repeat (LAT) tick();
    checks++;
    if (pulses0 !== 0) begin
      errors++;
      $display("FAIL stale_masked: pulses=%0d during pipeline fill, expected 0", pulses0);
    end
    exp_q.push_back(40'h100);
    tick();
    force_match = 1'b0;
    checks++;
    if (pulses0 !== 1) begin
      errors++;
      $display("FAIL stale_first_valid: pulses=%0d, expected 1", pulses0);
    end
    wait_done(600, 0, b0, b1);
    checks++;
    if (hc0 !== 8'd1) begin
      errors++;
      $display("FAIL stale_hit_count: got %0d, expected 1", hc0);
    end
  endtask

  task automatic test_stop_and_reset();
    int b0, b1;
    plant(39'h401, 2'b10, 40'h80_0000_0401);
    pulse_start(39'h400, 39'h4FF);
    repeat (79) tick();
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    checks++;
    if ({run0, busy0, done0} !== 3'b000 || hc0 !== 8'd1 || fk0 !== 40'h80_0000_0401) begin
      errors++;
      $display("FAIL stop_idle: run/busy/done=%b%b%b hit_count=%0d found_key=%h, expected 000 1 8000000401",
               run0, busy0, done0, hc0, fk0);
    end
    pulses0 = 0;
    plant(39'h12, 2'b10, 40'h80_0000_0012);
    pulse_start(39'h10, 39'h13);
    wait_done(400, 0, b0, b1);
    checks++;
    if (b0 !== 68 || pulses0 !== 1) begin
      errors++;
      $display("FAIL restart_after_stop: busy=%0d pulses=%0d, expected 68 and 1", b0, pulses0);
    end

    plant(39'h502, 2'b01, 40'h502);
    pulse_start(39'h500, 39'h5FF);
    repeat (74) tick();
    #2;
    reset_n_i = 1'b0;
    #1;
    checks++;
    if ({run0, busy0, done0, found0, hc0, key0, fk0} !== '0) begin
      errors++;
      $display("FAIL reset_mid_sweep: run/busy/done/found=%b%b%b%b hit_count=%h key=%h found_key=%h, all zero expected",
               run0, busy0, done0, found0, hc0, key0, fk0);
    end
    repeat (2) tick();
    reset_n_i = 1'b1;
    tick();

    pulses0 = 0;
    plant(39'h21, 2'b10, 40'h80_0000_0021);
    pulse_start(39'h20, 39'h23);
    wait_done(400, 0, b0, b1);
    checks++;
    if (b0 !== 68 || pulses0 !== 1 || hc0 !== 8'd1) begin
      errors++;
      $display("FAIL restart_after_reset: busy=%0d pulses=%0d hit_count=%0d, expected 68 1 1", b0, pulses0, hc0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_single_key();
    test_dup_and_stop_on_hit();
    test_pause();
    test_stale_pipeline();
    test_stop_and_reset();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drained: %0d expected hits never reported", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
